// File: rtl/operand_fetch_stage_if.sv
// Bundle between the operand fetch stage, its upstream issue logic and the
// downstream ALU array. Signal names follow the CPU datapath documentation.
//
// Handshake semantics: a transfer on either side happens on a rising edge
// where valid and ready are both high. Once out_valid is raised, A, B and the
// control bundle stay constant until the edge that consumes them; valid never
// drops without a transfer. in_ready depends only on out_valid and out_ready.
interface operand_fetch_stage_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 2
);
    // Upstream side
    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] RS;
    logic [REG_ADDR_W-1:0] RT;
    logic [2:0]            Funct;
    logic                  ImmEn;
    logic [DATA_W-1:0]     Imm;

    // Write-back port (independent of the handshake)
    logic                  WE;
    logic [REG_ADDR_W-1:0] WA;
    logic [DATA_W-1:0]     WD;

    // Downstream side (towards the ALU array)
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     A;
    logic [DATA_W-1:0]     B;
    logic                  BInvert;
    logic                  CIN;
    logic [2:0]            Operation;
    logic                  IllegalOp;

    // Environment view: drives instructions, write-back and downstream ready
    modport master (
        output in_valid, RS, RT, Funct, ImmEn, Imm,
        output WE, WA, WD,
        output out_ready,
        input  in_ready,
        input  out_valid, A, B, BInvert, CIN, Operation, IllegalOp
    );

    // Stage view
    modport slave (
        input  in_valid, RS, RT, Funct, ImmEn, Imm,
        input  WE, WA, WD,
        input  out_ready,
        output in_ready,
        output out_valid, A, B, BInvert, CIN, Operation, IllegalOp
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: architectural register file (R0 reads as zero), two
// bypassed read ports, immediate selection, function-code decode into the
// ALU slice controls, and a single-entry registered output buffer.
//
// Handshake: accept = in_valid && in_ready, with in_ready = !out_valid ||
// out_ready. The buffer is refilled on the same edge it is drained, so a
// continuously ready consumer sees one instruction per cycle with no bubble.
// While the buffer is full and not consumed, every output is frozen; later
// write-backs reach the register file but never the held operands.
module operand_fetch_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    operand_fetch_stage_if.slave     bus,
    output logic                     o_dbg_state
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    // Function codes
    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_OR  = 3'b001;
    localparam logic [2:0] FN_XOR = 3'b010;
    localparam logic [2:0] FN_ADD = 3'b011;
    localparam logic [2:0] FN_SUB = 3'b100;
    localparam logic [2:0] FN_SLT = 3'b101;

    // ALU result mux selects
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_SLT = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUM = 3'b100;

    // Output buffer occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    buf_state_t r_state;
    buf_state_t w_state_next;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_binvert;
    logic              r_cin;
    logic [2:0]        r_operation;
    logic              r_illegal;

    logic              w_out_valid;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_wb_active;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_b_src;
    logic              w_dec_binvert;
    logic              w_dec_cin;
    logic [2:0]        w_dec_operation;
    logic              w_dec_illegal;

    // Handshake terms; in_ready never looks at in_valid
    assign w_out_valid = (r_state == ST_FULL);
    assign w_in_ready  = !w_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;

    // A write to R0 is a no-op, so it must neither update nor bypass
    assign w_wb_active = bus.WE && (bus.WA != '0);

    // Register file write: runs every cycle, stalled or not
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_active) begin
            r_regs[bus.WA] <= bus.WD;
        end
    end

    // Read port A with write-back bypass; R0 is never written so reads 0
    always_comb begin
        w_rs_data = r_regs[bus.RS];
        if (w_wb_active && (bus.WA == bus.RS)) begin
            w_rs_data = bus.WD;
        end
    end

    // Read port B with write-back bypass
    always_comb begin
        w_rt_data = r_regs[bus.RT];
        if (w_wb_active && (bus.WA == bus.RT)) begin
            w_rt_data = bus.WD;
        end
    end

    // B operand source: immediate overrides the register read
    assign w_b_src = bus.ImmEn ? bus.Imm : w_rt_data;

    // Decode function code into ALU slice controls; SUB and SLT both need
    // A + ~B + 1, SLT then selects the less-than output of the MSB slice
    always_comb begin
        w_dec_operation = OP_AND;
        w_dec_binvert   = 1'b0;
        w_dec_cin       = 1'b0;
        w_dec_illegal   = 1'b0;
        case (bus.Funct)
            FN_AND: w_dec_operation = OP_AND;
            FN_OR:  w_dec_operation = OP_OR;
            FN_XOR: w_dec_operation = OP_XOR;
            FN_ADD: w_dec_operation = OP_SUM;
            FN_SUB: begin
                w_dec_operation = OP_SUM;
                w_dec_binvert   = 1'b1;
                w_dec_cin       = 1'b1;
            end
            FN_SLT: begin
                w_dec_operation = OP_SLT;
                w_dec_binvert   = 1'b1;
                w_dec_cin       = 1'b1;
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    // Buffer occupancy register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy: accept fills (also when draining), drain alone empties
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = ST_FULL;
        end else if (w_out_valid && bus.out_ready) begin
            w_state_next = ST_EMPTY;
        end
    end

    // Output payload: loaded only on accept, otherwise held
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_binvert   <= 1'b0;
            r_cin       <= 1'b0;
            r_operation <= OP_AND;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_a         <= w_rs_data;
            r_b         <= w_b_src;
            r_binvert   <= w_dec_binvert;
            r_cin       <= w_dec_cin;
            r_operation <= w_dec_operation;
            r_illegal   <= w_dec_illegal;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.BInvert   = r_binvert;
    assign bus.CIN       = r_cin;
    assign bus.Operation = r_operation;
    assign bus.IllegalOp = r_illegal;

    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset values, write then read,
// same-cycle bypass, R0 protection, stall freeze, drain, decode sweep and
// reset during a stall. Expected values are hand-computed constants.
module tb_operand_fetch_stage;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 2;

    logic clk = 1'b0;
    logic rst;
    logic dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected decode per Funct 000..111
    logic [2:0] exp_op  [8] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b100, 3'b001, 3'b000, 3'b000};
    logic       exp_inv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Clock
    always #5 clk = ~clk;

    operand_fetch_stage_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

    operand_fetch_stage #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic v, input logic [1:0] rs, input logic [1:0] rt,
                               input logic [2:0] fn, input logic imm_en, input logic [15:0] imm);
        bus.in_valid = v;
        bus.RS       = rs;
        bus.RT       = rt;
        bus.Funct    = fn;
        bus.ImmEn    = imm_en;
        bus.Imm      = imm;
    endtask

    task automatic drive_wb(input logic we, input logic [1:0] wa, input logic [15:0] wd);
        bus.WE = we;
        bus.WA = wa;
        bus.WD = wd;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [15:0] a,
                             input logic [15:0] b, input logic [2:0] op, input logic inv,
                             input logic cin, input logic ill);
        check_eq({tag, ".out_valid"}, 16'(bus.out_valid), 16'(ov));
        check_eq({tag, ".dbg_state"}, 16'(dbg_state), 16'(ov));
        check_eq({tag, ".A"}, bus.A, a);
        check_eq({tag, ".B"}, bus.B, b);
        check_eq({tag, ".Operation"}, 16'(bus.Operation), 16'(op));
        check_eq({tag, ".BInvert"}, 16'(bus.BInvert), 16'(inv));
        check_eq({tag, ".CIN"}, 16'(bus.CIN), 16'(cin));
        check_eq({tag, ".IllegalOp"}, 16'(bus.IllegalOp), 16'(ill));
    endtask

    initial begin
        // Reset with idle inputs
        rst = 1'b1;
        drive_instr(1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 16'h0000);
        drive_wb(1'b0, 2'd0, 16'h0000);
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_out("reset", 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
        check_eq("reset.in_ready", 16'(bus.in_ready), 16'd1);

        // Write R1, then a normal (non-bypassed) read of it
        drive_wb(1'b1, 2'd1, 16'h1234);
        step();
        check_eq("wr_idle.out_valid", 16'(bus.out_valid), 16'd0);
        drive_wb(1'b0, 2'd0, 16'h0000);
        drive_instr(1'b1, 2'd1, 2'd0, 3'b011, 1'b0, 16'h0000);
        step();
        check_out("add_r1", 1'b1, 16'h1234, 16'h0000, 3'b100, 1'b0, 1'b0, 1'b0);

        // Same-cycle bypass on both read ports
        drive_wb(1'b1, 2'd2, 16'hBEEF);
        drive_instr(1'b1, 2'd2, 2'd2, 3'b100, 1'b0, 16'h0000);
        step();
        check_out("bypass", 1'b1, 16'hBEEF, 16'hBEEF, 3'b100, 1'b1, 1'b1, 1'b0);

        // R0 protection: write ignored and not bypassed
        drive_wb(1'b1, 2'd0, 16'hFFFF);
        drive_instr(1'b1, 2'd0, 2'd0, 3'b000, 1'b0, 16'h0000);
        step();
        check_out("r0_bypass", 1'b1, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
        drive_wb(1'b0, 2'd0, 16'h0000);
        drive_instr(1'b1, 2'd0, 2'd2, 3'b001, 1'b0, 16'h0000);
        step();
        check_out("r0_read", 1'b1, 16'h0000, 16'hBEEF, 3'b010, 1'b0, 1'b0, 1'b0);

        // Load an XOR, then stall three cycles while R1 is rewritten
        drive_instr(1'b1, 2'd1, 2'd2, 3'b010, 1'b0, 16'h0000);
        step();
        check_out("pre_stall", 1'b1, 16'h1234, 16'hBEEF, 3'b011, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        drive_instr(1'b1, 2'd1, 2'd1, 3'b000, 1'b0, 16'h0000);
        #1;
        check_eq("stall.in_ready", 16'(bus.in_ready), 16'd0);
        for (int i = 0; i < 3; i++) begin
            drive_wb(1'b1, 2'd1, 16'h5550 + 16'(i));
            step();
            check_out("stall", 1'b1, 16'h1234, 16'hBEEF, 3'b011, 1'b0, 1'b0, 1'b0);
            check_eq("stall.in_ready", 16'(bus.in_ready), 16'd0);
        end

        // Release: back-to-back load sees the last stall-time write to R1
        drive_wb(1'b0, 2'd0, 16'h0000);
        bus.out_ready = 1'b1;
        drive_instr(1'b1, 2'd1, 2'd0, 3'b101, 1'b0, 16'h0000);
        #1;
        check_eq("release.in_ready", 16'(bus.in_ready), 16'd1);
        step();
        check_out("release", 1'b1, 16'h5552, 16'h0000, 3'b001, 1'b1, 1'b1, 1'b0);

        // Drain with no new instruction: valid drops, data retained
        drive_instr(1'b0, 2'd2, 2'd2, 3'b011, 1'b0, 16'h0000);
        step();
        check_out("drain", 1'b0, 16'h5552, 16'h0000, 3'b001, 1'b1, 1'b1, 1'b0);
        check_eq("drain.in_ready", 16'(bus.in_ready), 16'd1);

        // Decode sweep with immediate B operand
        for (int f = 0; f < 8; f++) begin
            drive_instr(1'b1, 2'd2, 2'd1, 3'(f), 1'b1, 16'hFFF0);
            step();
            check_out($sformatf("sweep%0d", f), 1'b1, 16'hBEEF, 16'hFFF0,
                      exp_op[f], exp_inv[f], exp_inv[f], exp_ill[f]);
        end

        // Reset during a stall, with a write-back and an offered instruction
        bus.out_ready = 1'b0;
        drive_instr(1'b1, 2'd2, 2'd2, 3'b011, 1'b0, 16'h0000);
        step();
        check_out("pre_rst_stall", 1'b1, 16'hBEEF, 16'hFFF0, 3'b000, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        drive_wb(1'b1, 2'd1, 16'hAAAA);
        step();
        rst = 1'b0;
        drive_wb(1'b0, 2'd0, 16'h0000);
        check_out("mid_rst", 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 1'b0);
        check_eq("mid_rst.in_ready", 16'(bus.in_ready), 16'd1);

        // Registers cleared and reset-cycle write discarded
        bus.out_ready = 1'b1;
        drive_instr(1'b1, 2'd1, 2'd2, 3'b011, 1'b0, 16'h0000);
        step();
        check_out("post_rst", 1'b1, 16'h0000, 16'h0000, 3'b100, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
